mul_sequencer: RTL
==================

Name: mul_sequencer

Overview:
- Multi-cycle controller that performs 32x32 MUL (low 32 bits of the product) by sequencing the existing EXE-stage ALU through repeated ADD operations (shift-add).
- Sits in the EXE stage beside the ALU. While busy it owns the ALU command/operand inputs through a mux in the EXE stage. It drives the stall request to the hazard unit.
- Produces the product and the NZCV status for the status register.

Parameters:
- WIDTH, 32, operand/product width; must match the ALU datapath.
- EARLY_EXIT, 1, when 1 iteration stops as soon as the remaining multiplier bits are zero; when 0 always 32 iterations.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- op_a  input  WIDTH  multiplicand (Rm).
- op_b  input  WIDTH  multiplier (Rs).
- set_flags  input  1  S bit of the MUL instruction; latched with start.
- status_in  input  4  current {N,Z,C,V} from the status register.
- alu_command  output  4  command to ALU.
- alu_operand1  output  WIDTH  ALU operand1.
- alu_operand2  output  WIDTH  ALU operand2.
- alu_result  input  WIDTH  combinational ALU result of the current cycle.
- busy  output  1  high in ITER; drives the pipeline stall.
- done  output  1  one-cycle pulse, product valid.
- product  output  WIDTH  registered result; held until next accepted start.
- status_out  output  4  {N,Z,C,V} for write-back; valid with done.
- status_we  output  1  equals done AND latched set_flags.

Behaviour:
- States: IDLE, ITER, DONE. Registers: M (multiplicand), Q (multiplier), ACC, cnt (6 bits), sf.
- Reset (rst=0 at a rising edge): state IDLE. M, Q, ACC, cnt, sf, product, status_out all cleared to 0. busy=0, done=0, status_we=0.
- Reset mid-operation aborts the multiply. No done is produced.

IDLE:
- busy=0.
- On start=1: load M=op_a, Q=op_b, ACC=0, cnt=0, sf=set_flags, then go to ITER.

ITER (busy=1):
- Exit condition: (EARLY_EXIT=1 and Q==0) or cnt==32.
  - If the exit condition holds: no update; product<=ACC; status_out<={ACC[31], ACC==0, status_in[1], status_in[0]}; go to DONE.
  - Otherwise one iteration is performed.
- One iteration: if Q[0]=1, ACC<=alu_result. Then M<=M<<1, Q<=Q>>1, cnt<=cnt+1.
- Arithmetic wraps mod 2^WIDTH. ALU carry and overflow are ignored. Signed and unsigned operands give identical low 32 bits.

DONE:
- done=1 and status_we=sf for exactly one cycle, then go to IDLE.
- start in the DONE cycle is ignored. The requester must re-assert it in IDLE.

ALU drive:
- When in ITER, not exiting, and Q[0]=1: alu_command=4'b0010 (ADD), alu_operand1=ACC, alu_operand2=M.
- All other cycles: alu_command=4'b0000, operands 0.

Other rules:
- start while busy or in DONE is ignored. It does not restart and is not queued.
- Latency: start sampled at edge E0; done high after edge E0+n+1.
  - EARLY_EXIT=1: n = index of highest set bit of op_b + 1 (0 when op_b=0).
  - EARLY_EXIT=0: n=32.
  - Maximum latency is 33 cycles.
- C and V are passed through from status_in. N and Z are taken from the final product.

Test Plan:
- op_a=7, op_b=6, set_flags=1 -> done after E0+4, product=42, status_out=0000|CV from status_in, status_we=1.
- op_a=0x1234, op_b=0 -> done after E0+1, product=0, status_out Z=1, ALU command stays 0000 throughout.
- op_a=op_b=0xFFFFFFFF -> 32 iterations, done after E0+33, product=0x00000001, N=0 Z=0. Same timing with EARLY_EXIT=0 for op_b=1.
- op_a=0xFFFFFFFD (-3), op_b=5, set_flags=0 -> product=0xFFFFFFF1, status_out N=1, status_we=0 at done.
- start pulsed again mid-ITER and in the DONE cycle -> ignored, single done pulse, product unchanged until the next IDLE start.
- rst=0 during ITER (cycle 3 of op_b=0xFF) -> next cycle IDLE, busy=0, product=0, no done. A subsequent start of 3*3 gives product=9.

Source files
------------

// File: rtl/mul_sequencer_if.sv
// Request/result and ALU-drive signals between the EXE stage and mul_sequencer.
// The slave modport is the sequencer; the master modport is the EXE stage side.
interface mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             set_flags;
    logic [3:0]       status_in;
    logic [3:0]       alu_command;
    logic [WIDTH-1:0] alu_operand1;
    logic [WIDTH-1:0] alu_operand2;
    logic [WIDTH-1:0] alu_result;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;
    logic [3:0]       status_out;
    logic             status_we;

    modport master (
        output start, op_a, op_b, set_flags, status_in, alu_result,
        input  alu_command, alu_operand1, alu_operand2, busy, done, product, status_out, status_we
    );

    modport slave (
        input  start, op_a, op_b, set_flags, status_in, alu_result,
        output alu_command, alu_operand1, alu_operand2, busy, done, product, status_out, status_we
    );
endinterface

// File: rtl/mul_sequencer.sv
// Shift-add MUL controller: borrows the EXE-stage ALU for one ADD per set multiplier bit
// and returns the low WIDTH bits of the product plus NZCV for write-back.
module mul_sequencer #(
    parameter int WIDTH      = 32,
    parameter int EARLY_EXIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    mul_sequencer_if.slave bus
);
    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [3:0]       ALU_NOP  = 4'b0000;
    localparam logic [3:0]       ALU_ADD  = 4'b0010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       status_q, status_d;
    logic             sf_q, sf_d;
    logic             exit_iter;

    // N and Z come from the product; C and V are not touched by MUL.
    function automatic logic [3:0] result_flags(input logic [WIDTH-1:0] res,
                                                input logic [3:0]       prev);
        result_flags = {res[WIDTH-1], (res == '0), prev[1], prev[0]};
    endfunction

    assign exit_iter = ((EARLY_EXIT != 0) && (q_q == '0)) || (cnt_q == CNT_LAST);

    always_comb begin
        state_d          = state_q;
        m_d              = m_q;
        q_d              = q_q;
        acc_d            = acc_q;
        cnt_d            = cnt_q;
        sf_d             = sf_q;
        product_d        = product_q;
        status_d         = status_q;
        bus.alu_command  = ALU_NOP;
        bus.alu_operand1 = '0;
        bus.alu_operand2 = '0;
        bus.busy         = 1'b0;
        bus.done         = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    m_d     = bus.op_a;
                    q_d     = bus.op_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sf_d    = bus.set_flags;
                    state_d = ITER;
                end
            end

            ITER: begin
                bus.busy = 1'b1;
                if (exit_iter) begin
                    product_d = acc_q;
                    status_d  = result_flags(acc_q, bus.status_in);
                    state_d   = DONE;
                end else begin
                    // The ALU is only borrowed on cycles that actually accumulate.
                    if (q_q[0]) begin
                        bus.alu_command  = ALU_ADD;
                        bus.alu_operand1 = acc_q;
                        bus.alu_operand2 = m_q;
                        acc_d            = bus.alu_result;
                    end
                    m_d   = m_q << 1;
                    q_d   = q_q >> 1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            q_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sf_q      <= 1'b0;
            product_q <= '0;
            status_q  <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sf_q      <= sf_d;
            product_q <= product_d;
            status_q  <= status_d;
        end
    end

    assign bus.product    = product_q;
    assign bus.status_out = status_q;
    assign bus.status_we  = (state_q == DONE) && sf_q;

endmodule
